// File: rtl/psum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : psum_accumulator
// Purpose  : Per-PE-row output stage. Accumulates NUM_TILES signed row sums
//            into one output element, requantizes the total with a rounding
//            arithmetic right shift plus saturation, and presents the result
//            through a single-entry valid/ready output register.
// Ports    : clk, rstn (async active-low)    - clock / reset
//            clear                           - synchronous soft clear
//            shift                           - right-shift amount (final beat)
//            in_valid/in_ready/psum_in       - row-sum input stream
//            out_valid/out_ready             - result handshake
//            out_data/out_acc/out_sat        - requantized result, raw sum, clip flag
//            tile_cnt                        - beats accepted in current group
// Revision : 1.0 - initial release
// ============================================================================
module psum_accumulator #(
  parameter int PARTIAL_SUM_BW = 20,
  parameter int ACC_BW         = 24,
  parameter int NUM_TILES      = 4,
  parameter int OUT_BW         = 8,
  parameter int SHIFT_BW       = 5,
  localparam int CNT_W         = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clear,
  input  logic [SHIFT_BW-1:0]       shift,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PARTIAL_SUM_BW-1:0] psum_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_BW-1:0]         out_data,
  output logic [ACC_BW-1:0]         out_acc,
  output logic                      out_sat,
  output logic [CNT_W-1:0]          tile_cnt
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_TILES - 1);
  // Saturation bounds expressed in the widened (ACC_BW+1) requantize domain.
  localparam logic signed [ACC_BW:0] C_MAX = (ACC_BW+1)'((64'sd1 <<< (OUT_BW - 1)) - 64'sd1);
  localparam logic signed [ACC_BW:0] C_MIN = -C_MAX - (ACC_BW+1)'(1);

  logic signed [ACC_BW-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]         tile_cnt_q, tile_cnt_d;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_BW-1:0]        out_data_q, out_data_d;
  logic [ACC_BW-1:0]        out_acc_q, out_acc_d;
  logic                     out_sat_q, out_sat_d;

  logic                     last_beat;
  logic                     accept;
  logic signed [ACC_BW-1:0] psum_ext;
  logic signed [ACC_BW-1:0] sum;
  logic signed [ACC_BW:0]   half;
  logic signed [ACC_BW:0]   rounded;
  logic signed [ACC_BW:0]   shifted;
  logic [OUT_BW-1:0]        sat_data;
  logic                     sat_flag;

  assign last_beat = (tile_cnt_q == C_LAST);
  // Only the final beat of a group needs room in the output register.
  assign in_ready  = !(last_beat && out_valid_q && !out_ready);
  // clear wins over an input beat even while in_ready reads 1.
  assign accept    = in_valid && in_ready && !clear;

  assign psum_ext  = ACC_BW'(signed'(psum_in));
  assign sum       = (tile_cnt_q == '0) ? psum_ext : (acc_q + psum_ext);

  // One extra bit of headroom so adding the rounding constant never wraps.
  assign half    = (shift == '0) ? '0 : ((ACC_BW+1)'(1) << (shift - SHIFT_BW'(1)));
  assign rounded = (ACC_BW+1)'(sum) + half;
  assign shifted = rounded >>> shift;

  always_comb begin
    sat_flag = 1'b0;
    sat_data = shifted[OUT_BW-1:0];
    if (shifted > C_MAX) begin
      sat_flag = 1'b1;
      sat_data = C_MAX[OUT_BW-1:0];
    end else if (shifted < C_MIN) begin
      sat_flag = 1'b1;
      sat_data = C_MIN[OUT_BW-1:0];
    end
  end

  always_comb begin
    acc_d       = acc_q;
    tile_cnt_d  = tile_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_acc_d   = out_acc_q;
    out_sat_d   = out_sat_q;
    if (clear) begin
      acc_d       = '0;
      tile_cnt_d  = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        acc_d = sum;
        if (last_beat) begin
          // A load here overrides the dequeue above so out_valid stays high.
          tile_cnt_d  = '0;
          out_valid_d = 1'b1;
          out_data_d  = sat_data;
          out_acc_d   = sum;
          out_sat_d   = sat_flag;
        end else begin
          tile_cnt_d = tile_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q       <= '0;
      tile_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_acc_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      tile_cnt_q  <= tile_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_acc_q   <= out_acc_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_acc   = out_acc_q;
  assign out_sat   = out_sat_q;
  assign tile_cnt  = tile_cnt_q;

endmodule
`default_nettype wire
